edge_list_reader: RTL and testbench

EDGE_LIST_READER -- requirements
Module: edge_list_reader

---
 rtl/edge_list_reader.sv | 126 ++++++++++++
 tb/tb_edge_list_reader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/edge_list_reader.sv
// Expands one vertex's edge range [start_off, end_off) into a stream of destination vertex ids,
// issuing one memory read per edge and handing each result downstream before the next read.
module edge_list_reader #(
   parameter int addr_width  = 64,
   parameter int data_width  = 64,
   parameter int input_width = 1 + 2*data_width,
   parameter int addr_inc    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [input_width-1:0] data_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [addr_width-1:0]  edge_base_addr,
   input  logic                   new_iteration,
   output logic                   mem_read,
   output logic [addr_width-1:0]  mem_addr,
   input  logic                   mem_resp,
   input  logic [data_width-1:0]  mem_rdata,
   output logic                   valid_o,
   output logic [data_width-1:0]  data_o,
   input  logic                   ready_i,
   output logic                   done,
   output logic [data_width-1:0]  edge_count
);

   typedef enum logic [1:0] {IDLE, CHECK, READ, OUTPUT} state_t;

   state_t                  state_reg;
   logic [data_width-1:0]   idx_reg;
   logic [data_width-1:0]   end_reg;
   logic                    last_reg;
   logic                    ready_reg;
   logic                    mem_read_reg;
   logic [addr_width-1:0]   mem_addr_reg;
   logic                    valid_reg;
   logic [data_width-1:0]   data_reg;
   logic                    done_reg;
   logic [data_width-1:0]   edge_count_reg;
   logic [data_width-1:0]   idx_next;

   assign idx_next = idx_reg + 1'b1;

   // Byte address of an edge-list entry; wraps naturally at the address width.
   function automatic logic [addr_width-1:0] entry_addr(input logic [addr_width-1:0] base,
                                                        input logic [data_width-1:0] i);
      return base + addr_width'(i) * addr_width'(addr_inc);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         end_reg        <= '0;
         last_reg       <= 1'b0;
         ready_reg      <= 1'b1;
         mem_read_reg   <= 1'b0;
         mem_addr_reg   <= '0;
         valid_reg      <= 1'b0;
         data_reg       <= '0;
         done_reg       <= 1'b0;
         edge_count_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (new_iteration)
                  edge_count_reg <= '0;
               if (valid_i) begin
                  idx_reg   <= data_i[data_width-1:0];
                  end_reg   <= data_i[2*data_width-1:data_width];
                  last_reg  <= data_i[2*data_width];
                  ready_reg <= 1'b0;
                  state_reg <= CHECK;
               end
            end
            CHECK: begin
               // Unsigned compare: an inverted range is treated like an empty one.
               if (idx_reg >= end_reg) begin
                  ready_reg <= 1'b1;
                  done_reg  <= last_reg;
                  state_reg <= IDLE;
               end else begin
                  mem_read_reg <= 1'b1;
                  mem_addr_reg <= entry_addr(edge_base_addr, idx_reg);
                  state_reg    <= READ;
               end
            end
            READ: begin
               if (mem_resp) begin
                  data_reg     <= mem_rdata;
                  mem_read_reg <= 1'b0;
                  valid_reg    <= 1'b1;
                  state_reg    <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (ready_i) begin
                  valid_reg      <= 1'b0;
                  idx_reg        <= idx_next;
                  edge_count_reg <= edge_count_reg + 1'b1;
                  if (idx_next == end_reg) begin
                     ready_reg <= 1'b1;
                     done_reg  <= last_reg;
                     state_reg <= IDLE;
                  end else begin
                     mem_read_reg <= 1'b1;
                     mem_addr_reg <= entry_addr(edge_base_addr, idx_next);
                     state_reg    <= READ;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ready_o    = ready_reg;
   assign mem_read   = mem_read_reg;
   assign mem_addr   = mem_addr_reg;
   assign valid_o    = valid_reg;
   assign data_o     = data_reg;
   assign done       = done_reg;
   assign edge_count = edge_count_reg;

endmodule

// File: tb/tb_edge_list_reader.sv
// Directed and randomized checks of edge_list_reader against a per-payload model:
// the expected reads are base + i*8 for every i in [start, end), each echoed downstream.
module tb_edge_list_reader;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int IW = 1 + 2*DW;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] data_i;
   logic          valid_i;
   logic          ready_o;
   logic [AW-1:0] edge_base_addr;
   logic          new_iteration;
   logic          mem_read;
   logic [AW-1:0] mem_addr;
   logic          mem_resp;
   logic [DW-1:0] mem_rdata;
   logic          valid_o;
   logic [DW-1:0] data_o;
   logic          ready_i;
   logic          done;
   logic [DW-1:0] edge_count;

   int            total = 0;
   int            bad = 0;
   logic [63:0]   exp_count = '0;

   edge_list_reader dut (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .edge_base_addr(edge_base_addr), .new_iteration(new_iteration),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i), .done(done), .edge_count(edge_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_ready"}, ready_o, 1'b1);
      chk1({tag, "_mem_read"}, mem_read, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, 64'd0);
      chk1({tag, "_valid"}, valid_o, 1'b0);
      chk({tag, "_data"}, data_o, 64'd0);
      chk1({tag, "_done"}, done, 1'b0);
      chk({tag, "_count"}, edge_count, 64'd0);
   endtask

   // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
   task automatic run_payload(input logic last, input logic [63:0] end_off, input logic [63:0] start_off,
                              input int lat, input int stall, input bit ni_in_read);
      logic [63:0] rd;
      logic [63:0] addr;
      logic [63:0] n;
      n = '0;
      chk1("idle_ready", ready_o, 1'b1);
      data_i  = {last, end_off, start_off};
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      chk1("check_ready", ready_o, 1'b0);
      chk1("check_noread", mem_read, 1'b0);
      for (logic [63:0] i = start_off; i < end_off; i++) begin
         @(negedge clk);
         addr = edge_base_addr + i * 64'd8;
         chk1("read_req", mem_read, 1'b1);
         chk("read_addr", mem_addr, addr);
         chk1("read_novalid", valid_o, 1'b0);
         chk1("read_notready", ready_o, 1'b0);
         if (ni_in_read) new_iteration = 1'b1;
         for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            new_iteration = 1'b0;
            chk1("read_hold", mem_read, 1'b1);
            chk("addr_hold", mem_addr, addr);
         end
         rd        = {$urandom, $urandom};
         mem_resp  = 1'b1;
         mem_rdata = rd;
         @(negedge clk);
         mem_resp      = 1'b0;
         new_iteration = 1'b0;
         mem_rdata     = ~rd;
         chk1("out_valid", valid_o, 1'b1);
         chk("out_data", data_o, rd);
         chk1("out_noread", mem_read, 1'b0);
         if (stall > 0) begin
            ready_i  = 1'b0;
            mem_resp = 1'b1;
         end
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk1("stall_valid", valid_o, 1'b1);
            chk("stall_data", data_o, rd);
            chk1("stall_noread", mem_read, 1'b0);
         end
         ready_i  = 1'b1;
         mem_resp = 1'b0;
         n++;
      end
      @(negedge clk);
      exp_count = exp_count + n;
      chk1("end_done", done, last);
      chk1("end_ready", ready_o, 1'b1);
      chk1("end_noread", mem_read, 1'b0);
      chk1("end_novalid", valid_o, 1'b0);
      chk("end_count", edge_count, exp_count);
      @(negedge clk);
      chk1("done_one_cycle", done, 1'b0);
   endtask

   initial begin
      logic [63:0] s;
      logic [63:0] e;
      int          r;
      rst = 1'b1; data_i = '0; valid_i = 1'b0; edge_base_addr = 64'h1000;
      new_iteration = 1'b0; mem_resp = 1'b0; mem_rdata = '0; ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Two edges at idx 1 and 2, memory answering two cycles after each request.
      run_payload(1'b0, 64'd3, 64'd1, 2, 0, 1'b0);
      // Empty range with last set: done only.
      run_payload(1'b1, 64'd5, 64'd5, 0, 0, 1'b0);
      // Downstream back-pressure for four cycles on each edge.
      run_payload(1'b1, 64'd2, 64'd0, 1, 4, 1'b0);

      // Reset while a read is outstanding.
      chk1("rst_pre_ready", ready_o, 1'b1);
      data_i  = {1'b0, 64'd4, 64'd0};
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      @(negedge clk);
      chk1("rst_pre_read", mem_read, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("midread_reset");
      exp_count = '0;
      run_payload(1'b0, 64'd1, 64'd0, 0, 0, 1'b0);

      // Bring the count to 7, then clear it in IDLE.
      run_payload(1'b0, 64'd7, 64'd1, 1, 1, 1'b0);
      chk("count_seven", edge_count, 64'd7);
      new_iteration = 1'b1;
      @(negedge clk);
      new_iteration = 1'b0;
      exp_count = '0;
      chk("count_cleared", edge_count, exp_count);
      // new_iteration pulses while reading must not clear the count.
      run_payload(1'b0, 64'd3, 64'd0, 1, 0, 1'b1);
      // Inverted range behaves as empty.
      run_payload(1'b0, 64'd2, 64'd9, 0, 0, 1'b0);

      for (int t = 0; t < 25; t++) begin
         edge_base_addr = {$urandom, $urandom};
         s = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 40));
         r = $urandom_range(0, 5);
         e = (r == 5) ? s - 64'd1 : s + 64'(r);
         run_payload(1'($urandom_range(0, 1)), e, s, $urandom_range(0, 3), $urandom_range(0, 2),
                     bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
